gate_result_checker: RTL and testbench
======================================

// Module: gate_result_checker
// PURPOSE
//  Downstream stage of the gate-level and/or/xor block: consumes its inputs a,b and outputs x,y,z.
//  Recomputes the expected and/or/xor per sampled vector and flags mismatches.
//  Counts passes and fails over a run of NUM_VEC vectors, then reports a pass/fail verdict.
//  Replaces $display-based checking in benches with a synthesizable self-check.
// PARAMETERS
//  CNT_W    8  width of pass_cnt/fail_cnt; counters saturate at 2**CNT_W-1
//  NUM_VEC  4  vectors per run (>=1); run ends after NUM_VEC sampled vectors
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      begin run; honoured only in IDLE
//  vld        in   1      a,b,x,y,z valid this cycle; honoured only in RUN
//  a, b       in   1      stimulus driven into the gate block
//  x, y, z    in   1      gate block results: and, or, xor
//  busy       out  1      1 while in RUN
//  done       out  1      one-cycle pulse at end of run
//  pass       out  1      verdict, 1 = fail_cnt==0; valid from done until next start
//  err_pulse  out  1      one-cycle pulse after a mismatching sample
//  err_vec    out  3      mismatch mask {x,y,z} of most recent failing sample
//  pass_cnt   out  CNT_W  matching vectors this run
//  fail_cnt   out  CNT_W  mismatching vectors this run
//  first_fail out  5      {a,b,x,y,z} of first failing vector (see CONFIGURATION)
//  first_vld  out  1      first_fail holds a captured vector
// BEHAVIOUR
//  Reset: state IDLE; every output 0; vector counter 0. Async assert, sync-safe deassert.
//  FSM: IDLE -start-> RUN; RUN -(NUM_VEC-th vld sampled)-> DONE; DONE -> IDLE (unconditional).
//  start in IDLE: clears pass_cnt, fail_cnt, err_vec, pass, first_fail, first_vld; next state RUN.
//  start in RUN or DONE: ignored. vld in IDLE or DONE: ignored, no counter change.
//  Sample (RUN & vld at rising edge): exp = {a&b, a|b, a^b}; mis = exp ^ {x,y,z}.
//   mis==0: pass_cnt+1. mis!=0: fail_cnt+1, err_vec<=mis, err_pulse=1 next cycle only.
//  Latency: counters, err_vec, err_pulse update at the sampling edge (1 cycle, registered).
//  Saturation: a counter at all-ones holds; vector counter still advances, run length unaffected.
//  done: Moore output of DONE, high exactly one cycle, the cycle after the last sample edge.
//   pass registered at that same edge; counters hold through DONE/IDLE until next start.
//  busy = (state==RUN); deasserts in the DONE cycle.
//  Back-to-back vld every cycle supported; gaps in vld allowed indefinitely.
//  Reset mid-run: immediate return to IDLE, all outputs 0, partial counts discarded.
//  Vector counter width = clog2(NUM_VEC+1); NUM_VEC=1 ends run on first sample.
// CONFIGURATION
//  GATE_CHK_CAPTURE_EN defined: on the first failing sample of a run, first_fail<={a,b,x,y,z},
//   first_vld<=1; later failures do not overwrite; cleared only by start or rst.
//  GATE_CHK_CAPTURE_EN undefined: capture logic absent; first_fail and first_vld tied to 0
//   (ports still present so the interface is identical).
// TESTING (CNT_W=8, NUM_VEC=4 unless stated)
//  1 rst pulse, no start, vld toggling -> busy=done=err_pulse=0, counts 0, state IDLE.
//  2 start; vld with {a,b,x,y,z}=00000,01011,10011,11110 -> pass_cnt=4, fail_cnt=0,
//    done 1 cycle after 4th sample, pass=1, busy falls with done.
//  3 start; 4th vector 11111 instead of 11110 -> err_pulse 1 cycle, err_vec=001,
//    pass_cnt=3, fail_cnt=1, pass=0.
//  4 CNT_W=2, NUM_VEC=6, all vectors 00111 -> fail_cnt saturates at 3, done after 6th sample.
//  5 start, 2 good vectors, assert rst mid-run -> immediate IDLE, counts 0;
//    then vld without start -> no count change; start during RUN -> ignored.
//  6 macro defined: fails 01000 then 10000 -> first_fail=01000, first_vld=1;
//    macro undefined: same stimulus -> first_fail=0, first_vld=0.

Source files
------------

// File: rtl/gate_result_checker.sv
// gate_result_checker: recomputes and/or/xor for each sampled vector, counts passes/fails over NUM_VEC vectors and reports a verdict.
// Define GATE_CHK_CAPTURE_EN to keep the first failing {a,b,x,y,z} of each run in first_fail.
module gate_result_checker #(
    parameter int CNT_W   = 8,
    parameter int NUM_VEC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [2:0]       err_vec,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [4:0]       first_fail,
    output logic             first_vld
);
    localparam int VC_W = $clog2(NUM_VEC + 1);
    localparam logic [VC_W-1:0] LAST = VC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [VC_W-1:0] vec_cnt;
    logic [2:0]      mis;
    logic            sample;

    assign mis    = {a & b, a | b, a ^ b} ^ {x, y, z};
    assign sample = (state == RUN) && vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_pulse <= 1'b0;
            err_vec   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            err_pulse <= sample && (mis != 3'b000);
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    vec_cnt  <= '0;
                    err_vec  <= '0;
                    pass_cnt <= '0;
                    fail_cnt <= '0;
                end
                RUN: if (vld) begin
                    vec_cnt <= vec_cnt + 1'b1;
                    if (mis == 3'b000) begin
                        pass_cnt <= (&pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
                    end else begin
                        fail_cnt <= (&fail_cnt) ? fail_cnt : fail_cnt + 1'b1;
                        err_vec  <= mis;
                    end
                    if (vec_cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // fail_cnt is still pre-update here, so fold in this sample's result
                        pass  <= (fail_cnt == '0) && (mis == 3'b000);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_CHK_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail <= '0;
            first_vld  <= 1'b0;
        end else if ((state == IDLE) && start) begin
            first_fail <= '0;
            first_vld  <= 1'b0;
        end else if (sample && (mis != 3'b000) && !first_vld) begin
            first_fail <= {a, b, x, y, z};
            first_vld  <= 1'b1;
        end
    end
`else
    assign first_fail = '0;
    assign first_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_gate_result_checker.sv
// tb_gate_result_checker: randomized and directed runs against a queue-based reference model.
module tb_gate_result_checker;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, vld = 1'b0, start2 = 1'b0, vld2 = 1'b0;
    logic a = 1'b0, b = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
    logic busy, done, pass, err_pulse, first_vld;
    logic [2:0] err_vec;
    logic [7:0] pass_cnt, fail_cnt;
    logic [4:0] first_fail;
    logic busy2, done2, pass2, err_pulse2, first_vld2;
    logic [2:0] err_vec2;
    logic [1:0] pass_cnt2, fail_cnt2;
    logic [4:0] first_fail2;
    int n_vec = 0, n_mis = 0;
    logic [4:0] q[$];

    always #5 clk = ~clk;

    gate_result_checker #(.CNT_W(8), .NUM_VEC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .x(x), .y(y), .z(z),
        .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse), .err_vec(err_vec),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail), .first_vld(first_vld));

    gate_result_checker #(.CNT_W(2), .NUM_VEC(6)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .vld(vld2), .a(a), .b(b), .x(x), .y(y), .z(z),
        .busy(busy2), .done(done2), .pass(pass2), .err_pulse(err_pulse2), .err_vec(err_vec2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .first_fail(first_fail2), .first_vld(first_vld2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected mismatch mask of one vector {a,b,x,y,z}, from the gate truth tables.
    function automatic logic [2:0] mask(input logic [4:0] v);
        int s = v[4] + v[3];
        logic [2:0] want = {s == 2, s >= 1, s == 1};
        return want ^ v[2:0];
    endfunction

    function automatic logic [4:0] rand_vec();
        logic [4:0] v = 5'($urandom);
        if ($urandom_range(0, 1) == 1) v[2:0] = v[2:0] ^ mask(v);
        return v;
    endfunction

    task automatic send(input logic [4:0] v, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            vld = 1'b0;
            {a, b, x, y, z} = 5'($urandom);
            @(negedge clk);
        end
        vld = 1'b1;
        {a, b, x, y, z} = v;
        @(negedge clk);
        vld = 1'b0;
        chk("err_pulse", err_pulse, mask(v) != 3'b000);
    endtask

    task automatic begin_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1'b1);
    endtask

    // Applies q as one run (start already issued) and checks the run's results.
    task automatic feed_and_check(input string tag, input bit gaps);
        int np = 0, nf = 0;
        logic [2:0] ev = '0;
        logic [4:0] ff = '0;
        bit fv = 0;
        foreach (q[i]) begin
            send(q[i], gaps);
            if (mask(q[i]) == 3'b000) np++;
            else begin
                nf++;
                ev = mask(q[i]);
                if (!fv) begin fv = 1; ff = q[i]; end
            end
            chk({tag, "_done"}, done, i == q.size() - 1);
            chk({tag, "_busy"}, busy, i != q.size() - 1);
        end
        chk({tag, "_pass"}, pass, nf == 0);
        chk({tag, "_pcnt"}, pass_cnt, np);
        chk({tag, "_fcnt"}, fail_cnt, nf);
        chk({tag, "_evec"}, err_vec, ev);
`ifdef GATE_CHK_CAPTURE_EN
        chk({tag, "_ff"}, first_fail, ff);
        chk({tag, "_fv"}, first_vld, fv);
`else
        chk({tag, "_ff"}, first_fail, 5'd0);
        chk({tag, "_fv"}, first_vld, 1'b0);
`endif
        @(negedge clk);
        chk({tag, "_done_fall"}, done, 1'b0);
        chk({tag, "_pcnt_hold"}, pass_cnt, np);
    endtask

    initial begin
        // 1: reset, vld toggling without start
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld = i[0];
            {a, b, x, y, z} = 5'b00111;
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
            chk("idle_err", err_pulse, 1'b0);
            chk("idle_fcnt", fail_cnt, 8'd0);
        end
        vld = 1'b0;
        // 2: all-good directed run
        q = '{5'b00000, 5'b01011, 5'b10011, 5'b11110};
        begin_run();
        feed_and_check("good", 0);
        // 3: single failure on the last vector
        q = '{5'b00000, 5'b01011, 5'b10011, 5'b11111};
        begin_run();
        feed_and_check("bad4", 0);
        // 6: two failures, only the first is captured
        q = '{5'b01000, 5'b10000, 5'b00000, 5'b11110};
        begin_run();
        feed_and_check("cap", 0);
        // randomized runs with and without vld gaps
        for (int r = 0; r < 20; r++) begin
            q.delete();
            repeat (4) q.push_back(rand_vec());
            begin_run();
            feed_and_check("rand", r[0]);
        end
        // 4: saturation on the CNT_W=2, NUM_VEC=6 instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld2 = 1'b1;
            {a, b, x, y, z} = 5'b00111;
            @(negedge clk);
            chk("sat_done", done2, i == 5);
        end
        vld2 = 1'b0;
        chk("sat_fcnt", fail_cnt2, 2'd3);
        chk("sat_pcnt", pass_cnt2, 2'd0);
        chk("sat_pass", pass2, 1'b0);
        chk("sat_evec", err_vec2, 3'b111);
        // 5: reset mid-run, then vld without start, then start during RUN
        begin_run();
        send(5'b00000, 0);
        send(5'b11110, 0);
        chk("mid_pcnt", pass_cnt, 8'd2);
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_pcnt", pass_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld = 1'b1;
            {a, b, x, y, z} = (i == 1) ? 5'b00111 : 5'b00000;
            @(negedge clk);
        end
        vld = 1'b0;
        chk("nostart_pcnt", pass_cnt, 8'd0);
        chk("nostart_fcnt", fail_cnt, 8'd0);
        chk("nostart_busy", busy, 1'b0);
        begin_run();
        send(5'b00000, 0);
        send(5'b00111, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 1'b1);
        chk("restart_pcnt", pass_cnt, 8'd1);
        chk("restart_fcnt", fail_cnt, 8'd1);
        send(5'b01011, 0);
        chk("restart_done3", done, 1'b0);
        send(5'b10011, 0);
        chk("restart_done", done, 1'b1);
        chk("restart_pcnt_end", pass_cnt, 8'd3);
        chk("restart_pass", pass, 1'b0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
